// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared FSM type, timing defaults and microsecond-to-cycle conversion for servo_pwm_gen
package servo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } servo_state_e;

    localparam int unsigned DEF_CLK_FREQ_HZ  = 100_000_000;
    localparam int unsigned DEF_PERIOD_US    = 20000;
    localparam int unsigned DEF_MIN_PULSE_US = 1000;
    localparam int unsigned DEF_MAX_PULSE_US = 2000;
    localparam int unsigned DEF_ANGLE_MAX    = 180;
    localparam int unsigned DEF_SLEW_DEG     = 10;

    // Product taken at 64 bits so a fast clock times a long interval cannot wrap.
    function automatic int unsigned us_to_cyc(input int unsigned clk_hz, input int unsigned us);
        logic [63:0] prod;
        prod = 64'(clk_hz) * 64'(us);
        return 32'(prod / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/servo_angle_slew.sv
// rtl/servo_angle_slew.sv - angle clamp and applied-angle register, rate-limited when SERVO_PWM_SLEW_EN is defined
module servo_angle_slew
    import servo_pkg::*;
#(
    parameter int unsigned ANGLE_MAX = DEF_ANGLE_MAX,
    parameter int unsigned SLEW_DEG  = DEF_SLEW_DEG
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [7:0] angle_i,
    output logic [7:0] angle_applied_o
);

`ifdef SERVO_PWM_SLEW_EN
    localparam bit SLEW_ON = 1'b1;
`else
    localparam bit SLEW_ON = 1'b0;
`endif

    // Without slew the step limit exceeds any 8-bit difference, so the target is reached in one load.
    localparam logic [8:0] STEP_LIM  = SLEW_ON ? 9'(SLEW_DEG) : 9'd256;
    localparam logic [7:0] ANGLE_LIM = 8'(ANGLE_MAX);

    logic [7:0] applied_q;
    logic [7:0] applied_d;
    logic [7:0] tgt;
    logic [7:0] diff;
    logic [7:0] step;
    logic       up;

    // Clamp the command, then move toward it by at most the step limit.
    always_comb begin
        tgt       = (angle_i > ANGLE_LIM) ? ANGLE_LIM : angle_i;
        up        = (tgt >= applied_q);
        diff      = up ? (tgt - applied_q) : (applied_q - tgt);
        step      = ({1'b0, diff} > STEP_LIM) ? STEP_LIM[7:0] : diff;
        applied_d = up ? (applied_q + step) : (applied_q - step);
    end

    // Applied angle only changes when the FSM starts a new period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            applied_q <= '0;
        end else if (load_i) begin
            applied_q <= applied_d;
        end
    end

    assign angle_applied_o = applied_q;

endmodule

// File: rtl/servo_pwm_gen.sv
// rtl/servo_pwm_gen.sv - 50 Hz servo PWM generator with period strobe; optional slew via SERVO_PWM_SLEW_EN
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
    parameter int unsigned PERIOD_US    = DEF_PERIOD_US,
    parameter int unsigned MIN_PULSE_US = DEF_MIN_PULSE_US,
    parameter int unsigned MAX_PULSE_US = DEF_MAX_PULSE_US,
    parameter int unsigned ANGLE_MAX    = DEF_ANGLE_MAX,
    parameter int unsigned SLEW_DEG     = DEF_SLEW_DEG
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic [7:0] angle,
    output logic       pwm,
    output logic       done_period,
    output logic [7:0] angle_applied
);

    localparam int unsigned PERIOD_CYC = us_to_cyc(CLK_FREQ_HZ, PERIOD_US);
    localparam int unsigned MIN_CYC    = us_to_cyc(CLK_FREQ_HZ, MIN_PULSE_US);
    localparam int unsigned STEP_CYC   = us_to_cyc(CLK_FREQ_HZ, MAX_PULSE_US - MIN_PULSE_US) / ANGLE_MAX;
    localparam int unsigned CNT_W      = $clog2(PERIOD_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

    servo_state_e     state_q;
    servo_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pwm_q;
    logic             done_q;
    logic             load;
    logic             period_end;
    logic [31:0]      width;
    logic             width_hit;

    servo_angle_slew #(
        .ANGLE_MAX (ANGLE_MAX),
        .SLEW_DEG  (SLEW_DEG)
    ) u_slew (
        .clk_i           (CLK),
        .rst_i           (RST),
        .load_i          (load),
        .angle_i         (angle),
        .angle_applied_o (angle_applied)
    );

    // 32 bits holds the widest pulse for any realistic clock and period.
    assign width     = 32'(MIN_CYC) + 32'(angle_applied) * 32'(STEP_CYC);
    assign width_hit = (32'(cnt_q) == (width - 32'd1));

    // Next state and counter; the angle is loaded only when a period starts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load       = 1'b0;
        period_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    load    = 1'b1;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (width_hit) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    period_end = 1'b1;
                    if (en) begin
                        load    = 1'b1;
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; pwm tracks the state being entered so it aligns with the load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= (state_d == ST_HIGH);
            done_q  <= period_end;
        end
    end

    assign pwm         = pwm_q;
    assign done_period = done_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb/tb_servo_pwm_gen.sv - scoreboard bench for servo_pwm_gen
module tb_servo_pwm_gen;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned PER_US = 2500;
    localparam int P      = CLK_HZ / 1_000_000 * PER_US;
    localparam int MIN_W  = CLK_HZ / 1_000_000 * 1000;
    localparam int STEP_W = (CLK_HZ / 1_000_000 * (2000 - 1000)) / 180;
    localparam int AMAX   = 180;
    localparam int SLEW   = 10;

    logic       clk = 1'b0;
    logic       RST;
    logic       en;
    logic [7:0] angle;
    logic       pwm;
    logic       done_period;
    logic [7:0] angle_applied;

    servo_pwm_gen #(
        .CLK_FREQ_HZ  (CLK_HZ),
        .PERIOD_US    (PER_US),
        .MIN_PULSE_US (1000),
        .MAX_PULSE_US (2000),
        .ANGLE_MAX    (AMAX),
        .SLEW_DEG     (SLEW)
    ) dut (
        .CLK           (clk),
        .RST           (RST),
        .en            (en),
        .angle         (angle),
        .pwm           (pwm),
        .done_period   (done_period),
        .angle_applied (angle_applied)
    );

    always #5 clk = ~clk;

    typedef struct {
        int applied;
        int width;
        bit first;
        bit aborted;
        bit bogus;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_done = 0;
    int   n_done = 0;
    int   prev_applied = 0;
    int   cmd[16];
    int   offs[16];

    function automatic void check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endfunction

    // Spec rule: clamp to ANGLE_MAX, then (with slew) move at most SLEW degrees.
    function automatic int model_apply(input int prev, input int c);
        int tgt;
        tgt = (c > AMAX) ? AMAX : c;
`ifdef SERVO_PWM_SLEW_EN
        if (tgt > prev + SLEW) return prev + SLEW;
        if (tgt < prev - SLEW) return prev - SLEW;
`endif
        return tgt;
    endfunction

    task automatic issue(input int c, input bit first, input bit aborted, input int abort_w);
        exp_t r;
        prev_applied = model_apply(prev_applied, c);
        r.applied = prev_applied;
        r.width   = aborted ? abort_w : MIN_W + STEP_W * prev_applied;
        r.first   = first;
        r.aborted = aborted;
        r.bogus   = 1'b0;
        exp_q.push_back(r);
        if (!aborted) exp_done++;
    endtask

    task automatic wait_cycles(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Runs n back-to-back periods from cmd[]/offs[]; the last period drops en at its offset.
    task automatic run_block(input int n);
        en    = 1'b1;
        angle = 8'(cmd[0]);
        issue(cmd[0], 1'b1, 1'b0, 0);
        wait_cycles(1);
        check("start_latency", int'(pwm), 1);
        for (int p = 0; p < n; p++) begin
            int c;
            int c1;
            c = offs[p];
            if (p != 3 && c > 1 && $urandom_range(0, 1) == 1) begin
                c1 = $urandom_range(0, c - 1);
                wait_cycles(c1);
                angle = 8'($urandom);
                wait_cycles(c - c1);
            end else begin
                wait_cycles(c);
            end
            if (p < n - 1) begin
                angle = 8'(cmd[p + 1]);
                issue(cmd[p + 1], 1'b0, 1'b0, 0);
            end else begin
                en    = 1'b0;
                angle = 8'($urandom);
            end
            wait_cycles(P - c);
        end
    endtask

    // Monitor: pops one expected record per pwm pulse and checks width, angle, period and strobe.
    int   cyc = 0;
    int   hi = 0;
    int   last_rise = 0;
    bit   have_rise = 1'b0;
    bit   prev_pwm = 1'b0;
    bit   prev_done = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        cyc++;
        if (done_period === 1'b1) begin
            n_done++;
            if (prev_done) check("done_one_cycle", 2, 1);
            if (have_rise) check("done_spacing", cyc - last_rise, P);
            else check("done_spurious", 1, 0);
        end
        if (pwm === 1'b1 && !prev_pwm) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
                cur.bogus = 1'b1;
            end else begin
                cur = exp_q.pop_front();
                check("angle_at_rise", int'(angle_applied), cur.applied);
                check("done_at_rise", int'(done_period), cur.first ? 0 : 1);
                if (!cur.first && have_rise) check("period_len", cyc - last_rise, P);
            end
            hi        = 1;
            last_rise = cyc;
            have_rise = 1'b1;
        end else if (pwm === 1'b1) begin
            hi++;
        end else if (prev_pwm) begin
            if (!cur.bogus) begin
                check("pulse_width", hi, cur.width);
                if (!cur.aborted) check("angle_hold", int'(angle_applied), cur.applied);
            end
            if (cur.aborted || cur.bogus) have_rise = 1'b0;
        end
        prev_pwm  = (pwm === 1'b1);
        prev_done = (done_period === 1'b1);
    end

    initial begin
        RST   = 1'b1;
        en    = 1'b0;
        angle = 8'd0;
        wait_cycles(3);
        check("rst_pwm", int'(pwm), 0);
        check("rst_done", int'(done_period), 0);
        check("rst_angle", int'(angle_applied), 0);
        RST = 1'b0;
        wait_cycles(2);

`ifdef SERVO_PWM_SLEW_EN
        for (int i = 0; i < 9; i++) cmd[i] = 90;
        for (int i = 9; i < 16; i++) cmd[i] = int'($urandom_range(0, 255));
`else
        cmd[0] = 90;
        cmd[1] = 0;
        cmd[2] = 255;
        cmd[3] = 30;
        cmd[4] = 150;
        for (int i = 5; i < 16; i++) cmd[i] = int'($urandom_range(0, 255));
`endif
        for (int i = 0; i < 16; i++) offs[i] = int'($urandom_range(1, P - 1));
        offs[3]  = 500;
        offs[5]  = P - 1;
        offs[11] = 100;
        run_block(12);
        wait_cycles(3000);
        check("idle_pwm", int'(pwm), 0);

        en    = 1'b1;
        angle = 8'd120;
        issue(120, 1'b1, 1'b1, 300);
        wait_cycles(300);
        RST = 1'b1;
        en  = 1'b0;
        wait_cycles(1);
        check("rst_mid_pwm", int'(pwm), 0);
        check("rst_mid_angle", int'(angle_applied), 0);
        check("rst_mid_done", int'(done_period), 0);
        RST          = 1'b0;
        prev_applied = 0;
        wait_cycles(50);
        check("post_rst_idle", int'(pwm), 0);

        for (int i = 0; i < 16; i++) begin
            cmd[i]  = int'($urandom_range(0, 255));
            offs[i] = int'($urandom_range(1, P - 1));
        end
        offs[1] = 100;
        run_block(2);
        wait_cycles(500);

        check("leftover_expect", exp_q.size(), 0);
        check("done_count", n_done, exp_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
